// File: rtl/csr_ex_wb_pipe.sv
// csr_ex_wb_pipe: Zicsr EX->MEM->WB pipe driving the CSR file write port, with MEM/WB read bypass when CSR_FWD_EN is defined
module csr_ex_wb_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  csr_op_e,
  input  logic [11:0] csr_addr_e,
  input  logic [4:0]  rs1_field_e,
  input  logic [31:0] rs1_data_e,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_raddr,
  output logic        csr_ren,
  output logic [31:0] csr_old_e,
  output logic        csr_hazard_e,
  output logic        csr_we_w,
  output logic [11:0] csr_waddr_w,
  output logic [31:0] csr_wdata_w
);
  logic        valid_e, we_e, m_hit, w_hit;
  logic        m_valid, m_we, w_valid, w_we;
  logic [11:0] m_addr, w_addr;
  logic [31:0] m_data, w_data, src_e, raw_e, new_e;
  always_comb begin
    valid_e = csr_op_e[1:0] != 2'b00;
    src_e = csr_op_e[2] ? {27'b0, rs1_field_e} : rs1_data_e;
    we_e = valid_e && (csr_op_e[1:0] == 2'b01 || rs1_field_e != 5'd0);
    m_hit = m_valid && m_we && m_addr[4:0] == csr_addr_e[4:0];
    w_hit = w_valid && w_we && w_addr[4:0] == csr_addr_e[4:0];
`ifdef CSR_FWD_EN
    raw_e = m_hit ? m_data : w_hit ? w_data : csr_rdata;
    csr_hazard_e = 1'b0;
`else
    raw_e = csr_rdata;
    csr_hazard_e = valid_e && (m_hit || w_hit);
`endif
    csr_old_e = valid_e ? raw_e : 32'd0;
    new_e = csr_op_e[1:0] == 2'b01 ? src_e :
            csr_op_e[1:0] == 2'b10 ? csr_old_e | src_e : csr_old_e & ~src_e;
    csr_raddr = csr_addr_e;
    csr_ren = valid_e;
    csr_we_w = w_valid && w_we;
    csr_waddr_w = w_addr;
    csr_wdata_w = w_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_we <= 1'b0;
      m_addr <= 12'd0;
      m_data <= 32'd0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_we <= 1'b0;
    end else if (!stall) begin
      m_valid <= valid_e;
      m_we <= we_e;
      m_addr <= csr_addr_e;
      m_data <= new_e;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid <= 1'b0;
      w_we <= 1'b0;
      w_addr <= 12'd0;
      w_data <= 32'd0;
    end else if (!stall) begin
      w_valid <= m_valid;
      w_we <= m_we;
      w_addr <= m_addr;
      w_data <= m_data;
    end
  end
endmodule

// File: tb/tb_csr_ex_wb_pipe.sv
// tb_csr_ex_wb_pipe: randomized and directed check of csr_ex_wb_pipe against a behavioural model
module tb_csr_ex_wb_pipe;
  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [2:0]  csr_op_e;
  logic [11:0] csr_addr_e;
  logic [4:0]  rs1_field_e;
  logic [31:0] rs1_data_e, csr_rdata;
  logic [11:0] csr_raddr;
  logic        csr_ren, csr_hazard_e, csr_we_w;
  logic [31:0] csr_old_e, csr_wdata_w;
  logic [11:0] csr_waddr_w;
  logic [31:0] env_file [32];
  logic [31:0] model_file [32];
  typedef struct packed {logic v; logic we; logic [11:0] a; logic [31:0] d;} ent_t;
  ent_t m, w;
  int total = 0, bad = 0;
  logic r, s, fl;
  logic [2:0] op;
  logic [11:0] a;
  logic [4:0] f;
  logic [31:0] d;
  always #5 clk = ~clk;
  assign csr_rdata = env_file[csr_raddr[4:0]];
  csr_ex_wb_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .csr_op_e(csr_op_e), .csr_addr_e(csr_addr_e), .rs1_field_e(rs1_field_e),
    .rs1_data_e(rs1_data_e), .csr_rdata(csr_rdata), .csr_raddr(csr_raddr),
    .csr_ren(csr_ren), .csr_old_e(csr_old_e), .csr_hazard_e(csr_hazard_e),
    .csr_we_w(csr_we_w), .csr_waddr_w(csr_waddr_w), .csr_wdata_w(csr_wdata_w)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic sr, input logic ss, input logic sf, input logic [2:0] sop,
                      input logic [11:0] sa, input logic [4:0] sfl, input logic [31:0] sd);
    logic vld, mh, wh, wr, hz;
    logic [31:0] src, old, nv;
    @(posedge clk);
    #1;
    rst = sr; stall = ss; flush = sf;
    csr_op_e = sop; csr_addr_e = sa; rs1_field_e = sfl; rs1_data_e = sd;
    @(negedge clk);
    chk("we_w", 32'(csr_we_w), 32'(w.v && w.we));
    chk("waddr_w", 32'(csr_waddr_w), 32'(w.a));
    chk("wdata_w", csr_wdata_w, w.d);
    if (csr_we_w) env_file[csr_waddr_w[4:0]] = csr_wdata_w;
    if (w.v && w.we) model_file[w.a[4:0]] = w.d;
    #1;
    vld = sop != 3'b000 && sop != 3'b100;
    src = sop[2] ? 32'(sfl) : sd;
    mh = m.v && m.we && m.a[4:0] == sa[4:0];
    wh = w.v && w.we && w.a[4:0] == sa[4:0];
`ifdef CSR_FWD_EN
    old = mh ? m.d : wh ? w.d : model_file[sa[4:0]];
    hz = 1'b0;
`else
    old = model_file[sa[4:0]];
    hz = vld && (mh || wh);
`endif
    if (!vld) old = 32'd0;
    case (sop)
      3'b001, 3'b101: nv = src;
      3'b010, 3'b110: nv = old | src;
      3'b011, 3'b111: nv = old & ~src;
      default: nv = 32'd0;
    endcase
    wr = vld && (sop == 3'b001 || sop == 3'b101 || sfl != 5'd0);
    chk("old_e", csr_old_e, old);
    chk("hazard_e", 32'(csr_hazard_e), 32'(hz));
    chk("raddr", 32'(csr_raddr), 32'(sa));
    chk("ren", 32'(csr_ren), 32'(vld));
    if (sr) begin
      m = '0;
      w = '0;
    end else begin
      if (!ss) w = m;
      if (sf) begin
        m.v = 1'b0;
        m.we = 1'b0;
      end else if (!ss) m = '{vld, wr, sa, nv};
    end
  endtask
  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'b000, 12'h000, 5'd0, 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      env_file[i] = 32'd0;
      model_file[i] = 32'd0;
    end
    m = '0; w = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    csr_op_e = 3'b000; csr_addr_e = 12'h0; rs1_field_e = 5'd0; rs1_data_e = 32'd0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 3'b000, 12'h000, 5'd0, 32'd0);
    nop(1);
    chk("rst_we", 32'(csr_we_w), 32'd0);
    chk("rst_wdata", csr_wdata_w, 32'd0);
    chk("rst_hazard", 32'(csr_hazard_e), 32'd0);
    step(0, 0, 0, 3'b001, 12'h340, 5'd1, 32'hDEADBEEF);
    chk("rw_old", csr_old_e, 32'd0);
    nop(2);
    chk("rw_we", 32'(csr_we_w), 32'd1);
    chk("rw_waddr", 32'(csr_waddr_w), 32'h340);
    chk("rw_wdata", csr_wdata_w, 32'hDEADBEEF);
    step(0, 0, 0, 3'b001, 12'h340, 5'd1, 32'h000000F0);
    nop(2);
    step(0, 0, 0, 3'b110, 12'h340, 5'h0F, 32'd0);
    nop(2);
    chk("rsi_wdata", csr_wdata_w, 32'h000000FF);
    step(0, 0, 0, 3'b011, 12'h340, 5'd3, 32'h0000003C);
    nop(2);
    chk("rc_wdata", csr_wdata_w, 32'h000000C3);
    step(0, 0, 0, 3'b010, 12'h340, 5'd0, 32'h0000FFFF);
    chk("rs0_old", csr_old_e, 32'h000000C3);
    nop(2);
    chk("rs0_we", 32'(csr_we_w), 32'd0);
`ifdef CSR_FWD_EN
    step(0, 0, 0, 3'b001, 12'h305, 5'd1, 32'h11);
    step(0, 0, 0, 3'b010, 12'h305, 5'd2, 32'h22);
    chk("fwd_mem_old", csr_old_e, 32'h11);
    nop(1);
    chk("fwd_wdata0", csr_wdata_w, 32'h11);
    nop(1);
    chk("fwd_wdata1", csr_wdata_w, 32'h33);
    step(0, 0, 0, 3'b001, 12'h305, 5'd1, 32'h44);
    nop(1);
    step(0, 0, 0, 3'b010, 12'h305, 5'd2, 32'h22);
    chk("fwd_wb_old", csr_old_e, 32'h44);
    nop(2);
    step(0, 0, 0, 3'b001, 12'h305, 5'd1, 32'h5A);
    step(0, 0, 0, 3'b010, 12'h345, 5'd0, 32'd0);
    chk("alias_old", csr_old_e, 32'h5A);
    nop(2);
`else
    step(0, 0, 0, 3'b001, 12'h305, 5'd1, 32'h11);
    step(0, 0, 1, 3'b010, 12'h305, 5'd2, 32'h22);
    chk("hz_cyc1", 32'(csr_hazard_e), 32'd1);
    step(0, 0, 1, 3'b010, 12'h305, 5'd2, 32'h22);
    chk("hz_cyc2", 32'(csr_hazard_e), 32'd1);
    step(0, 0, 0, 3'b010, 12'h305, 5'd2, 32'h22);
    chk("hz_clear", 32'(csr_hazard_e), 32'd0);
    chk("hz_old", csr_old_e, 32'h11);
    nop(2);
    chk("hz_wdata", csr_wdata_w, 32'h33);
    step(0, 0, 0, 3'b001, 12'h305, 5'd1, 32'h5A);
    step(0, 0, 1, 3'b010, 12'h345, 5'd0, 32'd0);
    chk("alias_hz", 32'(csr_hazard_e), 32'd1);
    nop(2);
`endif
    step(0, 0, 1, 3'b001, 12'h300, 5'd1, 32'h1);
    nop(2);
    chk("flush_we", 32'(csr_we_w), 32'd0);
    step(0, 0, 0, 3'b001, 12'h301, 5'd1, 32'h9);
    nop(1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 3'b000, 12'h000, 5'd0, 32'd0);
      chk("stall_we", 32'(csr_we_w), 32'd1);
      chk("stall_waddr", 32'(csr_waddr_w), 32'h301);
      chk("stall_wdata", csr_wdata_w, 32'h9);
    end
    nop(3);
    step(0, 0, 0, 3'b001, 12'h301, 5'd1, 32'h77);
    step(0, 0, 0, 3'b001, 12'h302, 5'd1, 32'h88);
    step(1, 0, 0, 3'b000, 12'h000, 5'd0, 32'd0);
    nop(1);
    chk("rst_mid_we", 32'(csr_we_w), 32'd0);
    chk("rst_mid_waddr", 32'(csr_waddr_w), 32'd0);
    nop(2);
    chk("rst_mid_file", env_file[2], 32'd0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 49) == 0;
      s = $urandom_range(0, 6) == 0;
      fl = $urandom_range(0, 9) == 0;
      op = 3'($urandom);
      a = {7'($urandom), 3'b000, 2'($urandom)};
      f = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      d = $urandom;
      step(r, s, fl, op, a, f, d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
